// File: rtl/dec_seq_onehot.sv
// Registered N-to-2^N one-hot decoder with direct, scan-up, scan-down and hold modes.
// Latency: d_in to d_out is 1 clock, blank to d_out is 1 clock. No backpressure: en=0 freezes index state.
module dec_seq_onehot #(
  parameter int SEL_W    = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic                  blank,
  input  logic [SEL_W-1:0]      d_in,
  output logic [(2**SEL_W)-1:0] d_out,
  output logic [SEL_W-1:0]      idx,
  output logic                  valid,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam int DIV_W = ($clog2(SCAN_DIV+1) < 1) ? 1 : $clog2(SCAN_DIV+1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV-1);

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  logic [SEL_W-1:0] r_idx;
  logic             r_valid;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_mode;
  logic             r_wrap;
  logic             r_blank_q;

  logic [SEL_W-1:0] w_idx_n;
  logic             w_valid_n;
  logic [DIV_W-1:0] w_div_n;
  logic [1:0]       w_mode_n;
  logic             w_wrap_n;
  logic             w_mode_chg;
  logic [OUT_W-1:0] w_one;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_div     <= '0;
      r_mode    <= MODE_DIRECT;
      r_wrap    <= 1'b0;
      r_blank_q <= 1'b0;
    end else begin
      r_idx     <= w_idx_n;
      r_valid   <= w_valid_n;
      r_div     <= w_div_n;
      r_mode    <= w_mode_n;
      r_wrap    <= w_wrap_n;
      r_blank_q <= blank;
    end
  end

  assign w_mode_chg = (mode != r_mode);

  always_comb begin
    w_idx_n   = r_idx;
    w_valid_n = r_valid;
    w_div_n   = r_div;
    w_mode_n  = r_mode;
    w_wrap_n  = 1'b0;
    if (en) begin
      w_mode_n = mode;
      case (mode)
        MODE_DIRECT: begin
          w_idx_n   = d_in;
          w_valid_n = 1'b1;
          w_div_n   = '0;
        end
        MODE_UP, MODE_DOWN: begin
          // Load wins over both a mode change and a coincident terminal-count step.
          if (load) begin
            w_idx_n   = d_in;
            w_valid_n = 1'b1;
            w_div_n   = '0;
          end else if (w_mode_chg) begin
            w_div_n = '0;
          end else if (r_div == DIV_LAST) begin
            w_div_n   = '0;
            w_valid_n = 1'b1;
            if (mode == MODE_UP) begin
              w_idx_n  = r_idx + 1'b1;
              w_wrap_n = (r_idx == {SEL_W{1'b1}});
            end else begin
              w_idx_n  = r_idx - 1'b1;
              w_wrap_n = (r_idx == {SEL_W{1'b0}});
            end
          end else begin
            w_div_n = r_div + 1'b1;
          end
        end
        MODE_HOLD: begin
          if (w_mode_chg) w_div_n = '0;
        end
        default: begin
          w_div_n = r_div;
        end
      endcase
    end
  end

  assign w_one = {{(OUT_W-1){1'b0}}, 1'b1};
  assign d_out = (r_valid && !r_blank_q) ? (w_one << r_idx) : '0;
  assign idx   = r_idx;
  assign valid = r_valid;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_dec_seq_onehot.sv
// Directed bench for dec_seq_onehot: SCAN_DIV=4 main instance plus a SCAN_DIV=1 instance.
module tb_dec_seq_onehot;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic        load;
  logic        blank;
  logic [3:0]  d_in;
  logic [15:0] d_out, d_out1;
  logic [3:0]  idx, idx1;
  logic        valid, valid1;
  logic        wrap, wrap1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dec_seq_onehot #(.SEL_W(4), .SCAN_DIV(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .blank(blank),
    .d_in(d_in), .d_out(d_out), .idx(idx), .valid(valid), .wrap(wrap)
  );

  dec_seq_onehot #(.SEL_W(4), .SCAN_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .blank(blank),
    .d_in(d_in), .d_out(d_out1), .idx(idx1), .valid(valid1), .wrap(wrap1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; blank = 1'b0; d_in = 4'h0;
    #2;
    total++; if (d_out !== 16'h0000) begin bad++; $display("FAIL reset_dout got=%h exp=0000", d_out); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (idx !== 4'h0) begin bad++; $display("FAIL reset_idx got=%h exp=0", idx); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    tick(); tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_direct_sweep();
    logic [15:0] exp;
    en = 1'b1; mode = 2'b00;
    for (int d = 0; d < 16; d++) begin
      d_in = 4'(d);
      tick();
      exp = 16'h0001 << d;
      total++; if (d_out !== exp) begin bad++; $display("FAIL direct_dout d=%0d got=%h exp=%h", d, d_out, exp); end
      total++; if (idx !== 4'(d)) begin bad++; $display("FAIL direct_idx d=%0d got=%h exp=%h", d, idx, d); end
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL direct_valid d=%0d got=%b exp=1", d, valid); end
    end
  endtask

  task automatic test_scan_up_wrap();
    logic [3:0]  e_idx;
    logic [15:0] e_out;
    mode = 2'b01; load = 1'b1; d_in = 4'hE;
    tick();
    load = 1'b0;
    total++; if (idx !== 4'hE || d_out !== 16'h4000) begin bad++; $display("FAIL up_load got idx=%h dout=%h exp idx=e dout=4000", idx, d_out); end
    for (int i = 1; i <= 12; i++) begin
      tick();
      e_idx = (i < 4) ? 4'hE : (i < 8) ? 4'hF : (i < 12) ? 4'h0 : 4'h1;
      e_out = 16'h0001 << e_idx;
      total++; if (idx !== e_idx) begin bad++; $display("FAIL up_idx clk=%0d got=%h exp=%h", i, idx, e_idx); end
      total++; if (d_out !== e_out) begin bad++; $display("FAIL up_dout clk=%0d got=%h exp=%h", i, d_out, e_out); end
      total++; if (wrap !== (i == 8)) begin bad++; $display("FAIL up_wrap clk=%0d got=%b exp=%b", i, wrap, (i == 8)); end
    end
  endtask

  task automatic test_scan_down_div1();
    logic [3:0] e_idx [4];
    e_idx[0] = 4'h1; e_idx[1] = 4'h0; e_idx[2] = 4'hF; e_idx[3] = 4'hE;
    mode = 2'b10; load = 1'b1; d_in = 4'h1;
    tick();
    load = 1'b0;
    total++; if (idx1 !== e_idx[0] || wrap1 !== 1'b0) begin bad++; $display("FAIL down_load got idx=%h wrap=%b exp idx=1 wrap=0", idx1, wrap1); end
    for (int i = 1; i < 4; i++) begin
      tick();
      total++; if (idx1 !== e_idx[i]) begin bad++; $display("FAIL down_idx clk=%0d got=%h exp=%h", i, idx1, e_idx[i]); end
      total++; if (wrap1 !== (i == 2)) begin bad++; $display("FAIL down_wrap clk=%0d got=%b exp=%b", i, wrap1, (i == 2)); end
    end
  endtask

  task automatic test_enable_hold_blank();
    mode = 2'b01; load = 1'b1; d_in = 4'h5;
    tick();
    load = 1'b0;
    tick(); tick();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (idx !== 4'h5 || d_out !== 16'h0020 || wrap !== 1'b0) begin bad++; $display("FAIL en_freeze clk=%0d got idx=%h dout=%h wrap=%b exp idx=5 dout=0020 wrap=0", i, idx, d_out, wrap); end
    end
    en = 1'b1; mode = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (idx !== 4'h5 || d_out !== 16'h0020) begin bad++; $display("FAIL hold clk=%0d got idx=%h dout=%h exp idx=5 dout=0020", i, idx, d_out); end
    end
    blank = 1'b1;
    #1;
    total++; if (d_out !== 16'h0020) begin bad++; $display("FAIL blank_latency got=%h exp=0020", d_out); end
    tick();
    total++; if (d_out !== 16'h0000) begin bad++; $display("FAIL blank_on got=%h exp=0000", d_out); end
    total++; if (idx !== 4'h5) begin bad++; $display("FAIL blank_idx got=%h exp=5", idx); end
    blank = 1'b0;
    tick();
    total++; if (d_out !== 16'h0020) begin bad++; $display("FAIL blank_off got=%h exp=0020", d_out); end
  endtask

  task automatic test_load_on_step();
    mode = 2'b01; load = 1'b1; d_in = 4'hF;
    tick();
    load = 1'b0;
    tick(); tick(); tick();
    total++; if (idx !== 4'hF) begin bad++; $display("FAIL ls_pre got=%h exp=f", idx); end
    load = 1'b1; d_in = 4'h3;
    tick();
    load = 1'b0;
    total++; if (idx !== 4'h3) begin bad++; $display("FAIL ls_idx got=%h exp=3", idx); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL ls_wrap got=%b exp=0", wrap); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++; if (idx !== ((i == 4) ? 4'h4 : 4'h3)) begin bad++; $display("FAIL ls_next clk=%0d got=%h exp=%h", i, idx, (i == 4) ? 4'h4 : 4'h3); end
    end
  endtask

  task automatic test_async_reset();
    mode = 2'b01; load = 1'b1; d_in = 4'h9;
    tick();
    load = 1'b0;
    tick();
    total++; if (idx !== 4'h9) begin bad++; $display("FAIL ar_pre got=%h exp=9", idx); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (d_out !== 16'h0000) begin bad++; $display("FAIL ar_dout got=%h exp=0000", d_out); end
    total++; if (idx !== 4'h0) begin bad++; $display("FAIL ar_idx got=%h exp=0", idx); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", valid); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      total++; if (idx !== ((i == 5) ? 4'h1 : 4'h0)) begin bad++; $display("FAIL ar_step clk=%0d got=%h exp=%h", i, idx, (i == 5) ? 4'h1 : 4'h0); end
      total++; if (valid !== (i == 5)) begin bad++; $display("FAIL ar_valid clk=%0d got=%b exp=%b", i, valid, (i == 5)); end
    end
    total++; if (d_out !== 16'h0002) begin bad++; $display("FAIL ar_dout_step got=%h exp=0002", d_out); end
  endtask

  initial begin
    test_reset();
    test_direct_sweep();
    test_scan_up_wrap();
    test_scan_down_div1();
    test_enable_hold_blank();
    test_load_on_step();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
